irq_exc_ctrl: RTL

//  Parametrised interrupt/exception controller that replaces the single interrupt input and the EPC

---
 rtl/irq_exc_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: edge-latched irq lines plus a synchronous fault, prioritised and vectored to IF.
// Latency: irq edge -> int_req in 1+DRAIN_CYC cycles; exception -> int_req/flush in 1 cycle; all outputs registered.
// Backpressure: int_req/vec_addr are held until int_ack; new irq edges only latch pending while busy.
module irq_exc_ctrl #(
  parameter int                     NUM_IRQ    = 4,
  parameter int                     PC_WIDTH   = 32,
  parameter int                     DRAIN_CYC  = 3,
  parameter logic [PC_WIDTH-1:0]    VEC_BASE   = '0,
  parameter logic [PC_WIDTH-1:0]    VEC_STRIDE = PC_WIDTH'(2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                exception,
  input  logic [2:0]          exc_cause,
  input  logic [PC_WIDTH-1:0] exc_pc,
  input  logic [PC_WIDTH-1:0] resume_pc,
  input  logic                int_ack,
  input  logic                rti,
  output logic                stall_if,
  output logic                flush,
  output logic                int_req,
  output logic [PC_WIDTH-1:0] vec_addr,
  output logic [PC_WIDTH-1:0] EPC,
  output logic [3:0]          cause,
  output logic [NUM_IRQ-1:0]  in_service
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_VEC,
    S_SERVICE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          id_q, id_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  irq_prev_q;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  clr;
  logic [2:0]          win_id;

  logic                stall_d, flush_d, req_d;
  logic [PC_WIDTH-1:0] vec_d, epc_d;
  logic [3:0]          cause_d;
  logic [NUM_IRQ-1:0]  svc_d;

  assign rise     = irq & ~irq_prev_q;
  assign eligible = pending_q & ~irq_mask;

  // Lowest eligible index wins; scanned high-to-low so the last hit is the lowest.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 3'(i);
    end
  end

  // Next-state and next-output logic; an exception overrides whatever the FSM is doing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    stall_d = stall_if;
    flush_d = 1'b0;
    req_d   = int_req;
    vec_d   = vec_addr;
    epc_d   = EPC;
    cause_d = cause;
    svc_d   = in_service;
    clr     = '0;

    if (exception) begin
      state_d = S_VEC;
      epc_d   = exc_pc;
      cause_d = {1'b0, exc_cause};
      flush_d = 1'b1;
      stall_d = 1'b0;
      svc_d   = '0;
      req_d   = 1'b1;
      vec_d   = VEC_BASE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|eligible) begin
            state_d = S_DRAIN;
            cnt_d   = CW'(DRAIN_CYC - 1);
            stall_d = 1'b1;
          end
        end
        S_DRAIN: begin
          if (!(|eligible)) begin
            // everything got masked off while draining: release IF and go back
            state_d = S_IDLE;
            stall_d = 1'b0;
          end else if (cnt_q == '0) begin
            id_d    = win_id;
            epc_d   = resume_pc;
            cause_d = {1'b1, win_id};
            stall_d = 1'b0;
            req_d   = 1'b1;
            vec_d   = VEC_BASE + (PC_WIDTH'(win_id) + PC_WIDTH'(1)) * VEC_STRIDE;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            clr     = NUM_IRQ'(1) << id_q;
            svc_d   = NUM_IRQ'(1) << id_q;
            req_d   = 1'b0;
            state_d = S_SERVICE;
          end
        end
        S_VEC: begin
          if (int_ack) begin
            req_d   = 1'b0;
            state_d = S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (rti) begin
            svc_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // a fresh edge on the acknowledged line survives the clear
    pending_d = (pending_q & ~clr) | rise;
  end

  // Edge history and pending latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq;
      pending_q  <= pending_d;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      stall_if   <= 1'b0;
      flush      <= 1'b0;
      int_req    <= 1'b0;
      vec_addr   <= '0;
      EPC        <= '0;
      cause      <= '0;
      in_service <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      stall_if   <= stall_d;
      flush      <= flush_d;
      int_req    <= req_d;
      vec_addr   <= vec_d;
      EPC        <= epc_d;
      cause      <= cause_d;
      in_service <= svc_d;
    end
  end

endmodule
